alarm_trigger: RTL

//  Decides when the alarm rings and drives blink_signal into the LED blinker stage.

---
 rtl/alarm_trigger.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alarm_trigger.sv
// Alarm ringing controller: time match on the 1 Hz tick, snooze/dismiss handling,
// ring auto-timeout and snooze limit; blink_signal follows the RINGING state.
module alarm_trigger #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                tick_1hz,
  input  logic [4:0]                          cur_hour,
  input  logic [5:0]                          cur_min,
  input  logic [5:0]                          cur_sec,
  input  logic [4:0]                          alarm_hour,
  input  logic [5:0]                          alarm_min,
  input  logic                                alarm_enable,
  input  logic                                snooze_btn,
  input  logic                                dismiss_btn,
  output logic                                blink_signal,
  output logic [1:0]                          alarm_state,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]     snooze_count
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] RINGING = 2'b01;
  localparam logic [1:0] SNOOZED = 2'b10;

  localparam int TMAX = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(MAX_SNOOZE + 1);

  localparam logic [TW-1:0] RING_LAST  = TW'(RING_TIMEOUT_S - 1);
  localparam logic [TW-1:0] SNZ_LOAD   = TW'(SNOOZE_S);
  localparam logic [TW-1:0] SNZ_LAST   = TW'(1);
  localparam logic [CW-1:0] SNZ_LIMIT  = CW'(MAX_SNOOZE);

  logic [TW-1:0] ring_timer;
  logic [TW-1:0] snooze_timer;
  logic          snooze_prev;
  logic          dismiss_prev;

  logic [1:0]    state_nxt;
  logic [TW-1:0] ring_nxt;
  logic [TW-1:0] snz_nxt;
  logic [CW-1:0] cnt_nxt;

  logic snooze_press;
  logic dismiss_press;
  logic time_match;

  assign snooze_press  = snooze_btn & ~snooze_prev;
  assign dismiss_press = dismiss_btn & ~dismiss_prev;
  assign time_match    = (cur_hour == alarm_hour) && (cur_min == alarm_min) &&
                         (cur_sec == 6'd0);

  always_comb begin
    state_nxt = alarm_state;
    ring_nxt  = ring_timer;
    snz_nxt   = snooze_timer;
    cnt_nxt   = snooze_count;
    case (alarm_state)
      IDLE: begin
        if (tick_1hz && alarm_enable && time_match) begin
          state_nxt = RINGING;
          ring_nxt  = '0;
        end
      end
      RINGING: begin
        if (!alarm_enable || dismiss_press) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (snooze_press && (snooze_count < SNZ_LIMIT)) begin
          state_nxt = SNOOZED;
          snz_nxt   = SNZ_LOAD;
          cnt_nxt   = snooze_count + CW'(1);
        end else if (tick_1hz) begin
          // A snooze press at the limit falls through so the timeout keeps running
          if (ring_timer == RING_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            ring_nxt = ring_timer + TW'(1);
          end
        end
      end
      SNOOZED: begin
        if (!alarm_enable || dismiss_press) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (tick_1hz) begin
          if (snooze_timer == SNZ_LAST) begin
            state_nxt = RINGING;
            ring_nxt  = '0;
          end else begin
            snz_nxt = snooze_timer - TW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Button history resets high so a button held through reset is not a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_state  <= IDLE;
      blink_signal <= 1'b0;
      snooze_count <= '0;
      ring_timer   <= '0;
      snooze_timer <= '0;
      snooze_prev  <= 1'b1;
      dismiss_prev <= 1'b1;
    end else begin
      alarm_state  <= state_nxt;
      blink_signal <= (state_nxt == RINGING);
      snooze_count <= cnt_nxt;
      ring_timer   <= ring_nxt;
      snooze_timer <= snz_nxt;
      snooze_prev  <= snooze_btn;
      dismiss_prev <= dismiss_btn;
    end
  end

endmodule
